vga_plot_receiver: RTL

//  Responder end of the CPU pixel-plot interface (x, y, write strobe). Each strobed plot command
//  is captured into a small FIFO and drained to the framebuffer write port under a ready/valid handshake.
//  A full-screen clear sequencer can also be requested. Sits between cpu (vgax/vgay/vgaw) and the framebuffer RAM.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/plot_fifo.sv | 56 +++++
 rtl/vga_plot_receiver.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared widths, raster limits, plot command layout and FSM state encoding
// for the CPU pixel-plot receiver.
`timescale 1ns/1ps
package vga_pkg;
    localparam int VGA_XW   = 8;
    localparam int VGA_YW   = 8;
    localparam int VGA_COLW = 3;
    localparam int VGA_XMAX = 159;
    localparam int VGA_YMAX = 119;

    typedef struct packed {
        logic [VGA_XW-1:0]   x;
        logic [VGA_YW-1:0]   y;
        logic [VGA_COLW-1:0] col;
    } plot_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } fsm_state_t;
endpackage

// File: rtl/plot_fifo.sv
// Synchronous DEPTH-entry FIFO of plot commands with occupancy count and a
// peek at the entry behind the head, so the drain side can stream without bubbles.
`timescale 1ns/1ps
module plot_fifo
    import vga_pkg::*;
#(
    parameter type T     = plot_cmd_t,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              head,
    output T              next,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;

    assign rd_nxt = rd_ptr + AW'(1);
    assign head   = mem[rd_ptr];
    assign next   = mem[rd_nxt];
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_nxt;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vga_plot_receiver.sv
// CPU pixel-plot responder: queues strobed plots and drains them, or a full-screen
// clear sweep, to the framebuffer write port. Optional VGA_PLOT_CLIP_EN drops off-screen plots.
`timescale 1ns/1ps
module vga_plot_receiver
    import vga_pkg::*;
#(
    parameter int XW    = VGA_XW,
    parameter int YW    = VGA_YW,
    parameter int COLW  = VGA_COLW,
    parameter int DEPTH = 4,
    parameter int XMAX  = VGA_XMAX,
    parameter int YMAX  = VGA_YMAX
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XW-1:0]   vgax,
    input  logic [YW-1:0]   vgay,
    input  logic            vgaw,
    input  logic [COLW-1:0] colour,
    input  logic            clear_req,
    input  logic [COLW-1:0] clear_col,
    output logic            busy,
    output logic            overflow,
    output logic            clear_done,
    output logic [XW-1:0]   fb_x,
    output logic [YW-1:0]   fb_y,
    output logic [COLW-1:0] fb_col,
    output logic            fb_we,
    input  logic            fb_ready
`ifdef VGA_PLOT_CLIP_EN
    ,
    output logic [7:0]      clip_count
`endif
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XW-1:0]   x;
        logic [YW-1:0]   y;
        logic [COLW-1:0] col;
    } cmd_t;

    cmd_t          din;
    cmd_t          head;
    cmd_t          nxt;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          clipped;
    logic          pending;
    fsm_state_t    state;

`ifdef VGA_PLOT_CLIP_EN
    assign clipped = (vgax > XW'(XMAX)) || (vgay > YW'(YMAX));
`else
    assign clipped = 1'b0;
`endif

    assign din  = '{x: vgax, y: vgay, col: colour};
    assign pop  = (state == DRAIN) && fb_we && fb_ready;
    assign push = vgaw && !clipped && (!full || pop);
    assign busy = full || pending || (state == CLEAR);

    plot_fifo #(
        .T     (cmd_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .next  (nxt),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // The presented plot stays in the FIFO until accepted; on accept the entry behind
    // it is loaded directly so back-to-back writes need no idle cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            overflow   <= 1'b0;
            clear_done <= 1'b0;
            fb_x       <= '0;
            fb_y       <= '0;
            fb_col     <= '0;
            fb_we      <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            if (vgaw && !clipped && full && !pop) overflow <= 1'b1;
            if (clear_req && (state != CLEAR)) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (pending && empty) begin
                        state   <= CLEAR;
                        pending <= 1'b0;
                        fb_x    <= '0;
                        fb_y    <= '0;
                        fb_col  <= clear_col;
                        fb_we   <= 1'b1;
                    end else if (!empty) begin
                        state  <= DRAIN;
                        fb_x   <= head.x;
                        fb_y   <= head.y;
                        fb_col <= head.col;
                        fb_we  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (fb_we && fb_ready) begin
                        if (count > CW'(1)) begin
                            fb_x   <= nxt.x;
                            fb_y   <= nxt.y;
                            fb_col <= nxt.col;
                        end else if (pending && !push) begin
                            state   <= CLEAR;
                            pending <= 1'b0;
                            fb_x    <= '0;
                            fb_y    <= '0;
                            fb_col  <= clear_col;
                        end else begin
                            state <= IDLE;
                            fb_we <= 1'b0;
                        end
                    end
                end
                CLEAR: begin
                    if (fb_we && fb_ready) begin
                        if ((fb_x == XW'(XMAX)) && (fb_y == YW'(YMAX))) begin
                            state      <= IDLE;
                            fb_we      <= 1'b0;
                            clear_done <= 1'b1;
                        end else if (fb_x == XW'(XMAX)) begin
                            fb_x <= '0;
                            fb_y <= fb_y + YW'(1);
                        end else begin
                            fb_x <= fb_x + XW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VGA_PLOT_CLIP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_count <= '0;
        end else if (vgaw && clipped && (clip_count != 8'hFF)) begin
            clip_count <= clip_count + 8'd1;
        end
    end
`endif
endmodule
